alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-003 id_valid  in  1  decode stage presents a valid instruction.
REQ-004 id_rs_addr, id_rt_addr  in  5 each  source register numbers.
REQ-005 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  instruction actually reads rs / rt.
REQ-007 id_shamt  in  5  shift amount field.
REQ-008 id_imm  in  32  already-extended immediate.
REQ-009 id_alusrc1  in  1  1: ALU A = zero-extended shamt; 0: A = forwarded rs.
REQ-010 id_alusrc2  in  1  1: ALU B = id_imm; 0: B = forwarded rt.
REQ-011 id_alufun  in  6  ALU function code, passed through unchanged.
REQ-012 id_sign  in  1  signed-compare/overflow flag, passed through.
REQ-013 id_memread, id_regwrite  in  1 each  load / writes-register control.
REQ-014 id_rd  in  5  destination register.
REQ-015 fwd_m_regwrite, fwd_m_rd, fwd_m_data  in  1/5/32  MEM-stage forwarding source.
REQ-016 fwd_w_regwrite, fwd_w_rd, fwd_w_data  in  1/5/32  WB-stage forwarding source.
REQ-017 flush  in  1  squash the instruction being captured (taken branch/jump).
REQ-018 stall_req  out  1  load-use hazard; decode and fetch must hold.
REQ-019 ex_valid  out  1  registered instruction is valid.
REQ-020 ex_a, ex_b  out  32 each  registered ALU operands.
REQ-021 ex_store_data  out  32  registered forwarded rt (store data).
REQ-022 ex_alufun, ex_sign, ex_memread, ex_regwrite, ex_rd  out  6/1/1/1/5  registered controls.

Function
REQ-023 All ex_* outputs SHALL be registers; capture-to-output latency one cycle.
REQ-024 Forwarded rs SHALL be: fwd_m_data if fwd_m_regwrite & fwd_m_rd==id_rs_addr & id_rs_addr!=0; else fwd_w_data if same test on W; else id_rs_data.
REQ-025 Forwarded rt SHALL use the identical rule with id_rt_addr; MEM has priority over WB when both match.
REQ-026 Register 0 SHALL never be forwarded; rs/rt address 0 always yields id_*_data.
REQ-027 ex_a SHALL be {27'b0,id_shamt} when id_alusrc1=1, else forwarded rs; ex_b SHALL be id_imm when id_alusrc2=1, else forwarded rt.
REQ-028 ex_store_data SHALL always be forwarded rt, independent of id_alusrc2.
REQ-029 stall_req SHALL be combinational: ex_valid & ex_memread & ex_rd!=0 & id_valid & ((id_uses_rs & ex_rd==id_rs_addr) | (id_uses_rt & ex_rd==id_rt_addr)).
REQ-030 Each edge SHALL load one of: BUBBLE if flush=1, or stall_req=1, or id_valid=0; else CAPTURE.
REQ-031 BUBBLE SHALL set ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=0, ex_alufun=0, ex_sign=0, ex_a=ex_b=ex_store_data=0.
REQ-032 flush SHALL take priority over stall_req; both asserted yields one bubble.
REQ-033 A load-use stall SHALL last exactly one cycle, since the bubble clears ex_memread.
REQ-034 Operands SHALL pass bit-exact; no arithmetic or width change beyond REQ-027 zero-extension.

Reset
REQ-035 reset=0 at a rising edge SHALL load the BUBBLE state of REQ-031, overriding flush, stall and capture.
REQ-036 stall_req SHALL be 0 in the cycle after reset, since ex_valid=0.
REQ-037 Reset asserted mid-stream SHALL discard the in-flight instruction; no partial state survives.

Verification
REQ-038 Plain capture: rs=3 (0x10), rt=4 (0x20), no forward matches, alusrc=00 -> next cycle ex_a=0x10, ex_b=0x20, ex_valid=1.
REQ-039 Double forward: fwd_m rd=3 data 0xAAAA and fwd_w rd=3 data 0xBBBB, both regwrite=1 -> ex_a=0xAAAA; with rs=0 -> ex_a=id_rs_data.
REQ-040 Load-use: lw r5 captured, next id uses rs=5 -> stall_req=1 one cycle, ex_valid=0 that cycle, instruction captured on the following edge.
REQ-041 Shift/immediate: alusrc1=1, shamt=31, alusrc2=1, imm=0xFFFF8000 -> ex_a=0x1F, ex_b=0xFFFF8000, ex_store_data=forwarded rt.
REQ-042 flush and stall_req asserted together -> single bubble (all ex_* zero); no duplicate capture.
REQ-043 reset=0 during valid stream -> all ex_* zero next edge; stall_req=0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand forwarding, load-use stall detection and the ID/EX pipeline register.
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_shamt,
    input  logic [31:0] id_imm,
    input  logic        id_alusrc1,
    input  logic        id_alusrc2,
    input  logic [5:0]  id_alufun,
    input  logic        id_sign,
    input  logic        id_memread,
    input  logic        id_regwrite,
    input  logic [4:0]  id_rd,
    input  logic        fwd_m_regwrite,
    input  logic [4:0]  fwd_m_rd,
    input  logic [31:0] fwd_m_data,
    input  logic        fwd_w_regwrite,
    input  logic [4:0]  fwd_w_rd,
    input  logic [31:0] fwd_w_data,
    input  logic        flush,
    output logic        stall_req,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_store_data,
    output logic [5:0]  ex_alufun,
    output logic        ex_sign,
    output logic        ex_memread,
    output logic        ex_regwrite,
    output logic [4:0]  ex_rd
);
    logic [31:0] rs_fwd, rt_fwd;
    logic        bubble;

    // MEM beats WB; register 0 is never forwarded
    always_comb begin
        rs_fwd = (fwd_m_regwrite && fwd_m_rd == id_rs_addr && id_rs_addr != 5'd0) ? fwd_m_data :
                 (fwd_w_regwrite && fwd_w_rd == id_rs_addr && id_rs_addr != 5'd0) ? fwd_w_data : id_rs_data;
        rt_fwd = (fwd_m_regwrite && fwd_m_rd == id_rt_addr && id_rt_addr != 5'd0) ? fwd_m_data :
                 (fwd_w_regwrite && fwd_w_rd == id_rt_addr && id_rt_addr != 5'd0) ? fwd_w_data : id_rt_data;
    end

    assign stall_req = ex_valid && ex_memread && ex_rd != 5'd0 && id_valid &&
                       ((id_uses_rs && ex_rd == id_rs_addr) || (id_uses_rt && ex_rd == id_rt_addr));
    assign bubble = !reset || flush || stall_req || !id_valid;

    always_ff @(posedge clk) begin
        if (bubble) begin
            ex_valid      <= 1'b0;
            ex_a          <= '0;
            ex_b          <= '0;
            ex_store_data <= '0;
            ex_alufun     <= '0;
            ex_sign       <= 1'b0;
            ex_memread    <= 1'b0;
            ex_regwrite   <= 1'b0;
            ex_rd         <= '0;
        end else begin
            ex_valid      <= 1'b1;
            ex_a          <= id_alusrc1 ? {27'b0, id_shamt} : rs_fwd;
            ex_b          <= id_alusrc2 ? id_imm : rt_fwd;
            ex_store_data <= rt_fwd;
            ex_alufun     <= id_alufun;
            ex_sign       <= id_sign;
            ex_memread    <= id_memread;
            ex_regwrite   <= id_regwrite;
            ex_rd         <= id_rd;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a behavioural model.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_uses_rs, id_uses_rt, id_alusrc1, id_alusrc2, id_sign, id_memread, id_regwrite;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_rd, fwd_m_rd, fwd_w_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm, fwd_m_data, fwd_w_data;
    logic [5:0]  id_alufun;
    logic        fwd_m_regwrite, fwd_w_regwrite, flush;
    logic        stall_req, ex_valid, ex_sign, ex_memread, ex_regwrite;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [5:0]  ex_alufun;
    logic [4:0]  ex_rd;
    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic v; logic [31:0] a, b, sd; logic [5:0] fun; logic sign, mr, rw; logic [4:0] rd;
    } ex_t;
    ex_t m;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_shamt(id_shamt), .id_imm(id_imm),
        .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
        .id_alufun(id_alufun), .id_sign(id_sign),
        .id_memread(id_memread), .id_regwrite(id_regwrite), .id_rd(id_rd),
        .fwd_m_regwrite(fwd_m_regwrite), .fwd_m_rd(fwd_m_rd), .fwd_m_data(fwd_m_data),
        .fwd_w_regwrite(fwd_w_regwrite), .fwd_w_rd(fwd_w_rd), .fwd_w_data(fwd_w_data),
        .flush(flush), .stall_req(stall_req), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
        .ex_alufun(ex_alufun), .ex_sign(ex_sign), .ex_memread(ex_memread),
        .ex_regwrite(ex_regwrite), .ex_rd(ex_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // value an instruction would read for a register, after the newest in-flight write
    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf);
        if (r == 0) return rf;
        if (fwd_m_regwrite && fwd_m_rd == r) return fwd_m_data;
        if (fwd_w_regwrite && fwd_w_rd == r) return fwd_w_data;
        return rf;
    endfunction

    task automatic step(input string tag);
        logic exp_stall;
        ex_t n;
        #1;
        exp_stall = m.v && m.mr && m.rd != 0 && id_valid &&
                    ((id_uses_rs && m.rd == id_rs_addr) || (id_uses_rt && m.rd == id_rt_addr));
        chk({tag, "_stall"}, 32'(stall_req), 32'(exp_stall));
        n = '0;
        if (reset && !flush && !exp_stall && id_valid) begin
            n.v    = 1'b1;
            n.a    = id_alusrc1 ? 32'(id_shamt) : fwd(id_rs_addr, id_rs_data);
            n.b    = id_alusrc2 ? id_imm : fwd(id_rt_addr, id_rt_data);
            n.sd   = fwd(id_rt_addr, id_rt_data);
            n.fun  = id_alufun;
            n.sign = id_sign;
            n.mr   = id_memread;
            n.rw   = id_regwrite;
            n.rd   = id_rd;
        end
        @(posedge clk);
        #1;
        m = n;
        chk({tag, "_valid"}, 32'(ex_valid), 32'(m.v));
        chk({tag, "_a"}, ex_a, m.a);
        chk({tag, "_b"}, ex_b, m.b);
        chk({tag, "_sd"}, ex_store_data, m.sd);
        chk({tag, "_ctl"}, {16'b0, ex_alufun, ex_sign, ex_memread, ex_regwrite, ex_rd},
            {16'b0, m.fun, m.sign, m.mr, m.rw, m.rd});
    endtask

    task automatic idle;
        reset = 1'b1; flush = 1'b0; id_valid = 1'b1;
        id_rs_addr = 5'd0; id_rt_addr = 5'd0; id_rs_data = '0; id_rt_data = '0;
        id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_shamt = 5'd0; id_imm = '0;
        id_alusrc1 = 1'b0; id_alusrc2 = 1'b0; id_alufun = 6'h21; id_sign = 1'b0;
        id_memread = 1'b0; id_regwrite = 1'b1; id_rd = 5'd9;
        fwd_m_regwrite = 1'b0; fwd_m_rd = 5'd0; fwd_m_data = '0;
        fwd_w_regwrite = 1'b0; fwd_w_rd = 5'd0; fwd_w_data = '0;
    endtask

    initial begin
        m = '0;
        idle();
        reset = 1'b0;
        id_rs_data = 32'h1234;
        step("reset");
        chk("reset_zero", ex_a | ex_b | ex_store_data | 32'(ex_valid), 32'h0);
        // plain capture
        idle();
        id_rs_addr = 5'd3; id_rs_data = 32'h10; id_rt_addr = 5'd4; id_rt_data = 32'h20;
        fwd_m_regwrite = 1'b1; fwd_m_rd = 5'd7; fwd_w_regwrite = 1'b1; fwd_w_rd = 5'd8;
        step("plain");
        chk("plain_a", ex_a, 32'h10);
        chk("plain_b", ex_b, 32'h20);
        // double forward, then rs=0
        fwd_m_rd = 5'd3; fwd_m_data = 32'hAAAA; fwd_w_rd = 5'd3; fwd_w_data = 32'hBBBB;
        step("dfwd");
        chk("dfwd_a", ex_a, 32'hAAAA);
        fwd_w_rd = 5'd4;
        step("wfwd");
        chk("wfwd_b", ex_b, 32'hBBBB);
        fwd_m_rd = 5'd0; fwd_w_rd = 5'd0; fwd_m_data = 32'hCCCC;
        id_rs_addr = 5'd0; id_rs_data = 32'h55;
        step("r0");
        chk("r0_a", ex_a, 32'h55);
        // load-use
        idle();
        id_memread = 1'b1; id_rd = 5'd5;
        step("lw");
        id_memread = 1'b0; id_rd = 5'd6; id_rs_addr = 5'd5; id_rs_data = 32'h77;
        step("use1");
        chk("use1_bubble", 32'(ex_valid), 32'h0);
        step("use2");
        chk("use2_cap", {31'b0, ex_valid} ^ ex_a, 32'h76);
        // shift/immediate
        idle();
        id_alusrc1 = 1'b1; id_shamt = 5'd31; id_alusrc2 = 1'b1; id_imm = 32'hFFFF8000;
        id_rt_addr = 5'd2; id_rt_data = 32'h1; fwd_w_regwrite = 1'b1; fwd_w_rd = 5'd2; fwd_w_data = 32'hDEAD;
        step("shimm");
        chk("shimm_a", ex_a, 32'h1F);
        chk("shimm_b", ex_b, 32'hFFFF8000);
        chk("shimm_sd", ex_store_data, 32'hDEAD);
        // flush together with stall
        idle();
        id_memread = 1'b1; id_rd = 5'd5;
        step("lw2");
        id_memread = 1'b0; id_rt_addr = 5'd5; flush = 1'b1;
        step("flst");
        chk("flst_zero", ex_a | ex_b | ex_store_data | 32'(ex_valid) | 32'(ex_rd), 32'h0);
        flush = 1'b0;
        step("flst_after");
        // reset mid-stream
        idle();
        id_rs_addr = 5'd1; id_rs_data = 32'h99; id_memread = 1'b1; id_rd = 5'd1;
        step("pre_rst");
        reset = 1'b0;
        step("mid_rst");
        reset = 1'b1;
        step("post_rst");
        // random traffic with small register space to force matches
        for (int i = 0; i < 400; i++) begin
            reset = $urandom_range(0, 24) != 0;
            flush = $urandom_range(0, 9) == 0;
            id_valid = $urandom_range(0, 7) != 0;
            id_rs_addr = 5'($urandom_range(0, 7)); id_rt_addr = 5'($urandom_range(0, 7));
            id_rs_data = $urandom; id_rt_data = $urandom;
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            id_shamt = 5'($urandom); id_imm = $urandom;
            id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom);
            id_alufun = 6'($urandom); id_sign = 1'($urandom);
            id_memread = $urandom_range(0, 2) == 0; id_regwrite = 1'($urandom);
            id_rd = 5'($urandom_range(0, 7));
            fwd_m_regwrite = 1'($urandom); fwd_m_rd = 5'($urandom_range(0, 7)); fwd_m_data = $urandom;
            fwd_w_regwrite = 1'($urandom); fwd_w_rd = 5'($urandom_range(0, 7)); fwd_w_data = $urandom;
            step("rand");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
